kamikaze_ifetch: RTL and testbench
==================================

Name: kamikaze_ifetch

Overview:
Instruction fetch stage of the kamikaze core. It owns the program counter and drives the instruction-memory address. It captures the instruction word that the synchronous instruction memory returns one cycle later. Fetched words go into a small prefetch FIFO that feeds the decode stage over a valid/ready handshake, and the stage accepts redirects (branch/jump/trap) from downstream.

Parameters:
RESET_PC, 32'h0000_0000, address of the first fetch after reset; bits [1:0] must be 0.
FIFO_DEPTH, 2, prefetch FIFO entries; legal values 2..8.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_i  in  1  reset; one clock, reset is asynchronous and active-low.
im_addr_o  out  32  instruction-memory byte address; bits [1:0] always 0.
im_data_i  in  32  instruction word; valid on the cycle after the address was presented.
inst_valid_o  out  1  FIFO head holds a valid instruction.
inst_ready_i  in  1  decode accepts the head this cycle.
inst_o  out  32  instruction word at FIFO head.
inst_pc_o  out  32  address the head instruction was fetched from.
redirect_i  in  1  flush the pipeline and restart fetch at redirect_pc_i.
redirect_pc_i  in  32  new fetch address; bits [1:0] ignored (treated as 0).

Behaviour:
- Reset (rst_i=0, async):
  - pc_q=RESET_PC, req_q=0, FIFO count=0, pointers=0.
  - inst_valid_o=0, inst_o=0, inst_pc_o=0.
  - im_addr_o=RESET_PC.
- Memory model: the address presented in cycle N returns data on im_data_i in cycle N+1. The memory always reads, so the stage alone decides which returned words are real.
- Address mux: im_addr_o = redirect_i ? {redirect_pc_i[31:2],2'b00} : pc_q. This path is combinational.
- Issue condition:
  - issue = redirect_i | (count + req_q - pop < FIFO_DEPTH), where pop = inst_valid_o & inst_ready_i.
  - At most one fetch is outstanding per cycle. Back-to-back issue sustains one instruction per cycle.
- On issue:
  - req_q<=1, addr_q<=im_addr_o, pc_q<=im_addr_o+4.
  - The add wraps mod 2^32, so 0xFFFF_FFFC is followed by 0x0000_0000.
- No issue: req_q<=0 and pc_q holds.
- Response:
  - If req_q=1 and there is no redirect this cycle, push {addr_q, im_data_i} into the FIFO at the tail.
  - A push and a pop in the same cycle are allowed; count is unchanged.
  - The credit rule guarantees a push never meets a full FIFO. An assertion fires if it does.
- Redirect (highest priority):
  - The FIFO is cleared (count=0, pointers reset).
  - The in-flight response (req_q) this cycle is discarded.
  - A pop in the same cycle is ignored and decode must not consume.
  - A fetch to the redirect target is issued in the same cycle, so the first redirected instruction is valid at the head 2 cycles after redirect_i rises.
  - A redirect on consecutive cycles is legal; the last one wins.
- Outputs:
  - inst_valid_o = (count != 0).
  - inst_o and inst_pc_o show the head entry and are held stable while valid and not ready.
  - When empty, inst_o and inst_pc_o hold their last values; this is don't-care for verification.
- Latency:
  - The first instruction after reset release is at the head on the 2nd rising edge after release: issue at edge 1, push at edge 2.
  - Throughput is 1 instruction per cycle while inst_ready_i stays high.
- Reset mid-operation (asynchronous assert at any time): all state returns to reset values immediately, and any in-flight response is dropped.

Test Plan:
- Reset release, ready=1, memory word[i]=i: inst_pc_o = 0x0, 0x4, 0x8 … on consecutive cycles from the 2nd edge, with inst_o = 0, 1, 2.
- Ready held 0 for 10 cycles: count saturates at FIFO_DEPTH (2) and im_addr_o stops advancing. When ready returns, the sequence resumes with no duplicate or skipped PC.
- redirect_i pulse with redirect_pc_i=0x100 while the FIFO is full: the next valid instruction is at pc 0x100 two cycles later, and no stale pc 0x8/0xC appears.
- redirect_pc_i=0x203 (misaligned): im_addr_o=0x200 and inst_pc_o=0x200.
- RESET_PC=0xFFFF_FFF8: the fetched pcs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset asserted mid-stream with the FIFO non-empty: inst_valid_o=0 within the same cycle. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/kamikaze_ifetch.sv
// kamikaze instruction fetch stage: PC, sync imem request,
// prefetch FIFO toward decode, downstream redirect.
module kamikaze_ifetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] im_addr_o,
    input  logic [31:0] im_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    fetch_entry_t  fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [31:0]   pc_q;
    logic [31:0]   addr_q;
    logic          req_q;

    logic          pop;
    logic          push;
    logic          issue;
    logic [CW:0]   occ;
    logic          unused_bits;

    assign unused_bits  = ^redirect_pc_i[1:0];

    assign im_addr_o    = redirect_i ? {redirect_pc_i[31:2], 2'b00} : pc_q;
    assign inst_valid_o = (count_q != '0);
    assign pop          = inst_valid_o & inst_ready_i;
    assign push         = req_q & ~redirect_i;

    // Occupancy counts the in-flight word so a push can never overflow.
    assign occ   = {1'b0, count_q} + (CW+1)'(req_q) - (CW+1)'(pop);
    assign issue = redirect_i | (occ < (CW+1)'(FIFO_DEPTH));

    assign inst_o    = fifo_q[rd_ptr_q].inst;
    assign inst_pc_o = fifo_q[rd_ptr_q].pc;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q   <= RESET_PC;
            addr_q <= '0;
            req_q  <= 1'b0;
        end else begin
            req_q <= issue;
            if (issue) begin
                addr_q <= im_addr_o;
                pc_q   <= im_addr_o + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
        end else if (redirect_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {addr_q, im_data_i};
                wr_ptr_q <= (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

`ifndef SYNTHESIS
    push_never_full: assert property (
        @(posedge clk_i) disable iff (!rst_i)
        push |-> (count_q != CW'(FIFO_DEPTH))
    );
`endif

endmodule

// File: tb/tb_kamikaze_ifetch.sv
// Bench for kamikaze_ifetch: ordered-PC stream model, stalls,
// redirects, async reset, PC wrap and randomized traffic.
module tb_kamikaze_ifetch;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] im_addr_o;
    logic [31:0] im_data_i;
    logic        inst_valid_o;
    logic        inst_ready_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    logic        w_rst;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;

    int unsigned pass_cnt;
    int unsigned total_cnt;
    logic [31:0] exp_pc;

    kamikaze_ifetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .im_addr_o    (im_addr_o),
        .im_data_i    (im_data_i),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i)
    );

    kamikaze_ifetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
        .clk_i        (clk_i),
        .rst_i        (w_rst),
        .im_addr_o    (w_addr),
        .im_data_i    (w_data),
        .inst_valid_o (w_valid),
        .inst_ready_i (w_ready),
        .inst_o       (w_inst),
        .inst_pc_o    (w_pc),
        .redirect_i   (w_redirect),
        .redirect_pc_i(w_redirect_pc)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Synchronous memory: word at byte address A holds A/4.
    always @(posedge clk_i) begin
        im_data_i <= im_addr_o >> 2;
        w_data    <= w_addr >> 2;
    end

    task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc);
        @(negedge clk_i);
        inst_ready_i  = r;
        redirect_i    = rd;
        redirect_pc_i = rpc;
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b0;
        inst_ready_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        repeat (2) @(negedge clk_i);
        #1;
        total_cnt++;
        if (inst_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (inst_o !== 32'h0) $display("FAIL reset_inst: got %h want 0", inst_o);
        else pass_cnt++;
        total_cnt++;
        if (inst_pc_o !== 32'h0) $display("FAIL reset_pc: got %h want 0", inst_pc_o);
        else pass_cnt++;
        total_cnt++;
        if (im_addr_o !== 32'h0) $display("FAIL reset_addr: got %h want 0", im_addr_o);
        else pass_cnt++;
        @(negedge clk_i);
        rst_i = 1'b1;
        inst_ready_i = 1'b1;
        cycle(1'b1, 1'b0, '0);
        total_cnt++;
        if (inst_valid_o !== 1'b0) $display("FAIL first_edge_valid: got %b want 0", inst_valid_o);
        else pass_cnt++;
        cycle(1'b1, 1'b0, '0);
        exp_pc = 32'h0;
        total_cnt++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || inst_o !== 32'h0)
            $display("FAIL first_fetch: got v=%b pc=%h i=%h want v=1 pc=%h i=0",
                     inst_valid_o, inst_pc_o, inst_o, exp_pc);
        else pass_cnt++;
        exp_pc += 32'd4;
    endtask

    task automatic test_stream;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, '0);
            total_cnt++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || inst_o !== (exp_pc >> 2))
                $display("FAIL stream: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         inst_valid_o, inst_pc_o, inst_o, exp_pc, exp_pc >> 2);
            else pass_cnt++;
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, '0);
            if (i >= 1) begin
                total_cnt++;
                if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || im_addr_o !== exp_pc + 32'd8)
                    $display("FAIL stall: got v=%b pc=%h addr=%h want v=1 pc=%h addr=%h",
                             inst_valid_o, inst_pc_o, im_addr_o, exp_pc, exp_pc + 32'd8);
                else pass_cnt++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, '0);
            total_cnt++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || inst_o !== (exp_pc >> 2))
                $display("FAIL stall_resume: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         inst_valid_o, inst_pc_o, inst_o, exp_pc, exp_pc >> 2);
            else pass_cnt++;
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_redirect;
        repeat (3) cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 32'h100);
        total_cnt++;
        if (im_addr_o !== 32'h100) $display("FAIL redirect_addr: got %h want 100", im_addr_o);
        else pass_cnt++;
        exp_pc = 32'h100;
        cycle(1'b1, 1'b0, '0);
        total_cnt++;
        if (inst_valid_o !== 1'b0) $display("FAIL redirect_flush: got v=%b want 0", inst_valid_o);
        else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b0, '0);
            total_cnt++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || inst_o !== (exp_pc >> 2))
                $display("FAIL redirect_stream: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         inst_valid_o, inst_pc_o, inst_o, exp_pc, exp_pc >> 2);
            else pass_cnt++;
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_misaligned;
        cycle(1'b1, 1'b1, 32'h203);
        total_cnt++;
        if (im_addr_o !== 32'h200) $display("FAIL misaligned_addr: got %h want 200", im_addr_o);
        else pass_cnt++;
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        total_cnt++;
        if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h200 || inst_o !== 32'h80)
            $display("FAIL misaligned_head: got v=%b pc=%h i=%h want v=1 pc=200 i=80",
                     inst_valid_o, inst_pc_o, inst_o);
        else pass_cnt++;
        exp_pc = 32'h204;
    endtask

    task automatic test_back_to_back;
        cycle(1'b1, 1'b1, 32'h400);
        cycle(1'b1, 1'b1, 32'h500);
        total_cnt++;
        if (im_addr_o !== 32'h500 || inst_valid_o !== 1'b0)
            $display("FAIL b2b_redirect: got addr=%h v=%b want addr=500 v=0",
                     im_addr_o, inst_valid_o);
        else pass_cnt++;
        exp_pc = 32'h500;
        cycle(1'b1, 1'b0, '0);
        total_cnt++;
        if (inst_valid_o !== 1'b0) $display("FAIL b2b_gap: got v=%b want 0", inst_valid_o);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, '0);
            total_cnt++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || inst_o !== (exp_pc >> 2))
                $display("FAIL b2b_stream: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         inst_valid_o, inst_pc_o, inst_o, exp_pc, exp_pc >> 2);
            else pass_cnt++;
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_async_reset;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        #2;
        rst_i = 1'b0;
        #1;
        total_cnt++;
        if (inst_valid_o !== 1'b0 || im_addr_o !== 32'h0)
            $display("FAIL async_reset: got v=%b addr=%h want v=0 addr=0",
                     inst_valid_o, im_addr_o);
        else pass_cnt++;
        @(negedge clk_i);
        rst_i = 1'b1;
        inst_ready_i = 1'b1;
        cycle(1'b1, 1'b0, '0);
        total_cnt++;
        if (inst_valid_o !== 1'b0) $display("FAIL async_restart_gap: got v=%b want 0", inst_valid_o);
        else pass_cnt++;
        exp_pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, '0);
            total_cnt++;
            if (inst_valid_o !== 1'b1 || inst_pc_o !== exp_pc || inst_o !== (exp_pc >> 2))
                $display("FAIL async_restart: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         inst_valid_o, inst_pc_o, inst_o, exp_pc, exp_pc >> 2);
            else pass_cnt++;
            exp_pc += 32'd4;
        end
    endtask

    task automatic test_wrap;
        logic [31:0] wp;
        @(negedge clk_i);
        inst_ready_i = 1'b0;
        w_rst = 1'b0;
        #1;
        total_cnt++;
        if (w_addr !== 32'hFFFF_FFF8 || w_valid !== 1'b0)
            $display("FAIL wrap_reset: got addr=%h v=%b want addr=fffffff8 v=0", w_addr, w_valid);
        else pass_cnt++;
        @(negedge clk_i);
        w_rst = 1'b1;
        w_ready = 1'b1;
        @(negedge clk_i);
        #1;
        wp = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1;
            total_cnt++;
            if (w_valid !== 1'b1 || w_pc !== wp || w_inst !== (wp >> 2))
                $display("FAIL wrap_stream: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         w_valid, w_pc, w_inst, wp, wp >> 2);
            else pass_cnt++;
            wp += 32'd4;
        end
        w_ready = 1'b0;
    endtask

    task automatic test_random;
        int unsigned since;
        logic        r;
        logic        rd;
        logic [31:0] rpc;
        since = 100;
        for (int i = 0; i < 400; i++) begin
            rd  = ($urandom_range(0, 15) == 0);
            r   = ($urandom_range(0, 3) != 0);
            rpc = $urandom & 32'h0000_FFFF;
            cycle(r, rd, rpc);
            total_cnt++;
            if (inst_valid_o !== (since >= 2))
                $display("FAIL rand_valid: got v=%b want %b (cycle %0d)",
                         inst_valid_o, since >= 2, i);
            else pass_cnt++;
            if (rd) begin
                total_cnt++;
                if (im_addr_o !== {rpc[31:2], 2'b00})
                    $display("FAIL rand_redirect_addr: got %h want %h", im_addr_o,
                             {rpc[31:2], 2'b00});
                else pass_cnt++;
            end else if (inst_valid_o && r) begin
                total_cnt++;
                if (inst_pc_o !== exp_pc || inst_o !== (exp_pc >> 2))
                    $display("FAIL rand_stream: got pc=%h i=%h want pc=%h i=%h",
                             inst_pc_o, inst_o, exp_pc, exp_pc >> 2);
                else pass_cnt++;
                exp_pc += 32'd4;
            end
            if (rd) begin
                exp_pc = {rpc[31:2], 2'b00};
                since  = 1;
            end else if (since < 100) begin
                since++;
            end
        end
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        exp_pc = '0;
        rst_i = 1'b0;
        inst_ready_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        w_rst = 1'b0;
        w_ready = 1'b0;
        w_redirect = 1'b0;
        w_redirect_pc = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_back_to_back();
        test_async_reset();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
